vector_floating_point_square_root_iterative: RTL and testbench
==============================================================

# vector_floating_point_square_root_iterative

- Multi-cycle, element-serial FP32 vector square root.
- Trades the single-cycle combinational path for one restoring-recurrence root bit per cycle.
- Accepts a whole vs2 register with a valid/ready handshake and returns a packed vd plus accumulated fflags.
- Sits in the vector execution stage as the low-area alternative square-root unit.

## Interface
- VLEN, default from riscv_v_pkg: vector register width; must be a multiple of 32.
- NUM_ELEMENTS, default VLEN/32: FP32 lanes per register.
- clock  input  1  rising-edge clock
- reset_n  input  1  reset; asynchronous, active-low
- issue_valid  input  1  operand valid
- issue_ready  output  1  unit idle, can accept
- vs2  input  VLEN  packed FP32 operands; element i is bits [32i+31:32i]
- vl  input  $clog2(NUM_ELEMENTS)+1  active element count; values above NUM_ELEMENTS are clamped to NUM_ELEMENTS
- result_valid  output  1  vd/fflags valid
- result_ready  input  1  consumer accepts result
- vd  output  VLEN  packed FP32 results
- fflags  output  5  {NV,DZ,OF,UF,NX}; only NV (bit 4) and NX (bit 0) are ever set

## Operation
- FSM states: IDLE, UNPACK, ITERATE, ROUND, DONE.
- IDLE
  - issue_ready=1.
  - On issue_valid, latch vs2 and vl, clear vd and fflags, set element index i=0.
  - Go to UNPACK, or to DONE if vl==0.
- UNPACK: classify element i and go to ROUND for special cases:
  - Subnormal inputs are treated as ±0 (DAZ).
  - NaN (any) → 0x7FC00000; NV set if sNaN.
  - Negative nonzero, including −inf → 0x7FC00000, NV.
  - ±0 → ±0.
  - +inf → +inf.
- UNPACK, normal input with biased exponent E:
  - Result exponent Er = (E + 126 + E[0]) >> 1.
  - Radicand = {1,frac}, shifted left 1 more when E is even.
  - Load a 50-bit radicand, clear the root and remainder, set count=25, go to ITERATE.
- ITERATE
  - One restoring step per cycle; produces one root bit MSB-first.
  - After 25 steps the root holds 24 significand bits plus a guard bit.
  - Then go to ROUND.
- ROUND
  - sticky = (remainder != 0).
  - Round-to-nearest-even: increment the 24-bit root if guard & (sticky | lsb).
  - Sqrt cannot carry out of the significand; no renormalisation.
  - NX is set if guard | sticky.
  - Write the result to vd element i and OR the element flags into fflags.
  - If i+1 < vl: i++ and go to UNPACK; otherwise go to DONE.
- Tail elements (index ≥ vl) are written 0x00000000.
- Rounding mode is fixed RNE; no frm input.
- DONE
  - result_valid=1; vd/fflags are held stable.
  - On result_ready, go to IDLE.
  - issue_valid is ignored outside IDLE.

## Timing
- Reset values: issue_ready=1 (state IDLE), result_valid=0, vd=0, fflags=0; all internal registers cleared.
- Normal element: 27 cycles (UNPACK 1 + ITERATE 25 + ROUND 1).
- Special element: 2 cycles (UNPACK, ROUND).
- result_valid rises on the cycle after the last ROUND.
- Latency from the accepting edge: sum of per-element cycles, + 1 cycle to enter DONE.
- Full register of normal operands: 27·NUM_ELEMENTS + 1 cycles.
- vl==0: result_valid rises 1 cycle after acceptance, with vd=0 and fflags=0.
- Back-to-back issue:
  - issue_ready returns the cycle after the result_ready handshake.
  - There is no combinational ready-to-ready path.
- Reset asserted mid-ITERATE: everything returns immediately to the reset values; the partial result is discarded.

## Structure
- dragonfang_floating_point_pkg gains:
  - FP32_CANONICAL_NAN (32'h7FC00000)
  - FP32_BIAS (127)
  - the state enum sqrt_state_t
  - the fflags bit-index constants
- VLEN is taken from riscv_v_pkg.
- One sub-module, fp32_square_root_recurrence_step.
  - Purely combinational single restoring iteration.
  - Inputs: remainder, root, next radicand bit pair.
  - Outputs: next remainder and root.
  - Instantiated once in the top-level FSM.

## Test plan
- vl=1, element 0 = 0x40800000 (4.0) → vd[31:0]=0x40000000, fflags=0, result_valid 28 cycles after the accepting edge.
- Element 0x40000000 (2.0) → 0x3FB504F3, NX (fflags=5'b00001). Element 0x3F800000 (1.0) → 0x3F800000, no NX.
- Specials, in lanes 0–4:
  - 0xBF800000 → 0x7FC00000 with NV.
  - 0x80000000 → 0x80000000.
  - 0x7F800000 → 0x7F800000.
  - 0xFF800000 → 0x7FC00000 with NV.
  - 0x7F800001 (sNaN) → 0x7FC00000 with NV.
  - Latency 2 cycles per lane.
- Tail and empty vectors:
  - vl=2 with all lanes 4.0 → lanes 0–1 = 0x40000000, remaining lanes 0.
  - vl=0 → result_valid 1 cycle after acceptance, vd=0.
- Backpressure: hold result_ready=0 for 10 cycles in DONE.
  - vd, fflags and result_valid are stable.
  - issue_ready=0; a new issue_valid is not accepted.
- Reset pulse during lane 0 ITERATE → all outputs at reset values next cycle; a fresh issue completes correctly.

Source files
------------

// File: rtl/vector_floating_point_square_root_iterative_pkg.sv
// Shared constants for the iterative FP32 vector square-root unit: vector
// register geometry plus the FP32 encodings, flag indices and FSM states.
package riscv_v_pkg;
  localparam int VLEN = 256;
endpackage

package dragonfang_floating_point_pkg;
  localparam logic [31:0] FP32_CANONICAL_NAN = 32'h7FC00000;
  localparam logic [31:0] FP32_POS_INF       = 32'h7F800000;
  localparam int          FP32_BIAS          = 127;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  // 50-bit radicand yields a 25-bit root (24 significand bits + guard).
  localparam int SQRT_RAD_W  = 50;
  localparam int SQRT_ROOT_W = 25;
  localparam int SQRT_REM_W  = 28;
  localparam int SQRT_STEPS  = 25;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ITERATE,
    ROUND,
    DONE
  } sqrt_state_t;
endpackage

// File: rtl/vector_floating_point_square_root_iterative_if.sv
// Issue/result handshake bundle between the vector pipe and the sqrt unit.
interface vector_floating_point_square_root_iterative_if #(
  parameter int VLEN         = riscv_v_pkg::VLEN,
  parameter int NUM_ELEMENTS = VLEN / 32
);
  localparam int VL_W = $clog2(NUM_ELEMENTS) + 1;

  logic            issue_valid;
  logic            issue_ready;
  logic [VLEN-1:0] vs2;
  logic [VL_W-1:0] vl;
  logic            result_valid;
  logic            result_ready;
  logic [VLEN-1:0] vd;
  logic [4:0]      fflags;

  modport master (
    output issue_valid, vs2, vl, result_ready,
    input  issue_ready, result_valid, vd, fflags
  );

  modport slave (
    input  issue_valid, vs2, vl, result_ready,
    output issue_ready, result_valid, vd, fflags
  );
endinterface

// File: rtl/vector_floating_point_square_root_iterative_step.sv
// One restoring square-root iteration: brings down a radicand bit pair and
// decides the next root bit.
module fp32_square_root_recurrence_step
  import dragonfang_floating_point_pkg::*;
(
  input  logic [SQRT_REM_W-1:0]  remainder,
  input  logic [SQRT_ROOT_W-1:0] root,
  input  logic [1:0]             radicand_pair,
  output logic [SQRT_REM_W-1:0]  remainder_next,
  output logic [SQRT_ROOT_W-1:0] root_next
);
  logic [SQRT_REM_W-1:0] shifted;
  logic [SQRT_REM_W-1:0] trial;
  logic                  fits;

  always_comb begin
    // Remainder stays below 2*root+1, so its top two bits are always zero.
    shifted        = {remainder[SQRT_REM_W-3:0], radicand_pair};
    trial          = {{(SQRT_REM_W-SQRT_ROOT_W-2){1'b0}}, root, 2'b01};
    fits           = (shifted >= trial);
    remainder_next = fits ? (shifted - trial) : shifted;
    root_next      = {root[SQRT_ROOT_W-2:0], fits};
  end
endmodule

// File: rtl/vector_floating_point_square_root_iterative.sv
// Element-serial FP32 vector square root: one restoring root bit per cycle,
// RNE rounding, DAZ on subnormal inputs.
module vector_floating_point_square_root_iterative
  import dragonfang_floating_point_pkg::*;
#(
  parameter int VLEN         = riscv_v_pkg::VLEN,
  parameter int NUM_ELEMENTS = VLEN / 32
) (
  input logic clock,
  input logic reset_n,
  vector_floating_point_square_root_iterative_if.slave io
);
  localparam int VL_W = $clog2(NUM_ELEMENTS) + 1;

  sqrt_state_t             state, state_next;
  logic [VLEN-1:0]         vs2_q, vd_q;
  logic [VL_W-1:0]         vl_q, idx;
  logic [4:0]              fflags_q, count;
  logic [SQRT_RAD_W-1:0]   radicand;
  logic [SQRT_REM_W-1:0]   remainder, remainder_step;
  logic [SQRT_ROOT_W-1:0]  root, root_step;
  logic [7:0]              exp_res;
  logic                    special;
  logic [31:0]             special_res;
  logic [4:0]              special_flags;

  logic [31:0]             elem;
  logic                    elem_sign;
  logic [7:0]              elem_exp;
  logic [22:0]             elem_frac;
  logic                    spec_c;
  logic [31:0]             spec_res_c;
  logic [4:0]              spec_flags_c;
  logic [7:0]              exp_c;
  logic [SQRT_RAD_W-1:0]   rad_c;
  logic                    guard, sticky, round_up;
  logic [22:0]             frac_rounded;
  logic [31:0]             elem_res;
  logic [4:0]              elem_flags;
  logic                    more_elems;

  fp32_square_root_recurrence_step u_step (
    .remainder      (remainder),
    .root           (root),
    .radicand_pair  (radicand[SQRT_RAD_W-1:SQRT_RAD_W-2]),
    .remainder_next (remainder_step),
    .root_next      (root_step)
  );

  always_comb begin
    elem = '0;
    for (int k = 0; k < NUM_ELEMENTS; k++)
      if (idx == VL_W'(k)) elem = vs2_q[32*k +: 32];
    {elem_sign, elem_exp, elem_frac} = elem;

    spec_c       = 1'b1;
    spec_flags_c = '0;
    spec_res_c   = FP32_CANONICAL_NAN;
    if (elem_exp == 8'h00) begin
      spec_res_c = {elem_sign, 31'b0};
    end else if (elem_exp == 8'hFF) begin
      if (elem_frac != '0)  spec_flags_c[FFLAG_NV] = ~elem_frac[22];
      else if (elem_sign)   spec_flags_c[FFLAG_NV] = 1'b1;
      else                  spec_res_c = FP32_POS_INF;
    end else if (elem_sign) begin
      spec_flags_c[FFLAG_NV] = 1'b1;
    end else begin
      spec_c = 1'b0;
    end

    // (E + 126 + E[0]) >> 1 rewritten to avoid the discarded LSB.
    exp_c = {1'b0, elem_exp[7:1]} + 8'((FP32_BIAS - 1) / 2) + {7'b0, elem_exp[0]};
    rad_c = elem_exp[0] ? {2'b01, elem_frac, 25'b0} : {1'b1, elem_frac, 26'b0};

    guard        = root[0];
    sticky       = |remainder;
    round_up     = guard & (sticky | root[1]);
    frac_rounded = root[23:1] + {22'b0, round_up};
    elem_flags   = '0;
    if (special) begin
      elem_res   = special_res;
      elem_flags = special_flags;
    end else begin
      elem_res   = {1'b0, exp_res, frac_rounded};
      elem_flags[FFLAG_NX] = guard | sticky;
    end

    more_elems = (idx + VL_W'(1)) < vl_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next      = state;
    io.issue_ready  = (state == IDLE);
    io.result_valid = (state == DONE);
    io.vd           = vd_q;
    io.fflags       = fflags_q;
    case (state)
      IDLE:    if (io.issue_valid) state_next = (io.vl == '0) ? DONE : UNPACK;
      UNPACK:  state_next = spec_c ? ROUND : ITERATE;
      ITERATE: if (count == 5'd1) state_next = ROUND;
      ROUND:   state_next = more_elems ? UNPACK : DONE;
      DONE:    if (io.result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs2_q <= '0; vd_q <= '0; vl_q <= '0; idx <= '0; fflags_q <= '0;
      count <= '0; radicand <= '0; remainder <= '0; root <= '0;
      exp_res <= '0; special <= 1'b0; special_res <= '0; special_flags <= '0;
    end else begin
      case (state)
        IDLE: if (io.issue_valid) begin
          vs2_q    <= io.vs2;
          vl_q     <= (io.vl > VL_W'(NUM_ELEMENTS)) ? VL_W'(NUM_ELEMENTS) : io.vl;
          vd_q     <= '0;
          fflags_q <= '0;
          idx      <= '0;
        end
        UNPACK: begin
          special       <= spec_c;
          special_res   <= spec_res_c;
          special_flags <= spec_flags_c;
          exp_res       <= exp_c;
          radicand      <= rad_c;
          remainder     <= '0;
          root          <= '0;
          count         <= 5'(SQRT_STEPS);
        end
        ITERATE: begin
          radicand  <= {radicand[SQRT_RAD_W-3:0], 2'b00};
          remainder <= remainder_step;
          root      <= root_step;
          count     <= count - 5'd1;
        end
        ROUND: begin
          for (int k = 0; k < NUM_ELEMENTS; k++)
            if (idx == VL_W'(k)) vd_q[32*k +: 32] <= elem_res;
          fflags_q <= fflags_q | elem_flags;
          if (more_elems) idx <= idx + VL_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_floating_point_square_root_iterative.sv
// Directed bench for the iterative FP32 vector square root (8 lanes).
module tb_vector_floating_point_square_root_iterative;
  localparam int VLEN = 256;
  localparam int NUM  = 8;
  localparam int VL_W = 4;

  logic clock;
  logic reset_n;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  vector_floating_point_square_root_iterative_if #(.VLEN(VLEN), .NUM_ELEMENTS(NUM)) io ();

  vector_floating_point_square_root_iterative #(.VLEN(VLEN), .NUM_ELEMENTS(NUM)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (io)
  );

  typedef struct {
    string           name;
    logic [VLEN-1:0] vs2;
    logic [VL_W-1:0] vl;
    logic [VLEN-1:0] vd;
    logic [4:0]      flags;
    int              lat;
  } vec_t;

  vec_t vecs[8];
  int checks = 0;
  int errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk5(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Latency counts the accepting edge as cycle 1.
  task automatic run_vec(input logic [VLEN-1:0] v, input logic [VL_W-1:0] l,
                         output logic [VLEN-1:0] vd_o, output logic [4:0] fl_o,
                         output int lat);
    @(negedge clock);
    chk1("issue_ready before issue", io.issue_ready, 1'b1);
    io.vs2 = v;
    io.vl = l;
    io.issue_valid = 1'b1;
    @(posedge clock); #1;
    io.issue_valid = 1'b0;
    lat = 1;
    while (!io.result_valid && lat < 400) begin
      @(posedge clock); #1;
      lat++;
    end
    vd_o = io.vd;
    fl_o = io.fflags;
    @(negedge clock);
    io.result_ready = 1'b1;
    @(posedge clock); #1;
    io.result_ready = 1'b0;
    chk1("issue_ready after handshake", io.issue_ready, 1'b1);
    chk1("result_valid after handshake", io.result_valid, 1'b0);
  endtask

  initial begin
    logic [VLEN-1:0] got_vd;
    logic [4:0]      got_fl;
    int              got_lat;
    int              n;

    io.issue_valid  = 1'b0;
    io.vs2          = '0;
    io.vl           = '0;
    io.result_ready = 1'b0;
    reset_n         = 1'b0;

    vecs[0] = '{"sqrt4", {8{32'h40800000}}, 4'd1, {224'h0, 32'h40000000}, 5'b00000, 28};
    vecs[1] = '{"sqrt2", {{7{32'h3F800000}}, 32'h40000000}, 4'd1, {224'h0, 32'h3FB504F3}, 5'b00001, 28};
    vecs[2] = '{"sqrt1", {{7{32'h40000000}}, 32'h3F800000}, 4'd1, {224'h0, 32'h3F800000}, 5'b00000, 28};
    vecs[3] = '{"specials", {32'h40800000, 32'h40800000, 32'h40800000, 32'h7F800001,
                             32'hFF800000, 32'h7F800000, 32'h80000000, 32'hBF800000}, 4'd5,
                {96'h0, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h7FC00000},
                5'b10000, 11};
    vecs[4] = '{"tail_vl2", {8{32'h40800000}}, 4'd2, {192'h0, 32'h40000000, 32'h40000000}, 5'b00000, 55};
    vecs[5] = '{"empty_vl0", {8{32'h40800000}}, 4'd0, {VLEN{1'b0}}, 5'b00000, 1};
    vecs[6] = '{"clamp_vl15", {8{32'h3F800000}}, 4'd15, {8{32'h3F800000}}, 5'b00000, 217};
    vecs[7] = '{"mixed", {{4{32'h40000000}}, 32'h7FC00001, 32'h00000001, 32'h3E800000, 32'h41100000}, 4'd4,
                {128'h0, 32'h7FC00000, 32'h00000000, 32'h3F000000, 32'h40400000}, 5'b00000, 59};

    repeat (3) @(posedge clock);
    #1;
    chk1("reset issue_ready", io.issue_ready, 1'b1);
    chk1("reset result_valid", io.result_valid, 1'b0);
    chkv("reset vd", io.vd, '0);
    chk5("reset fflags", io.fflags, 5'b0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i].vs2, vecs[i].vl, got_vd, got_fl, got_lat);
      chkv($sformatf("%s vd", vecs[i].name), got_vd, vecs[i].vd);
      chk5($sformatf("%s fflags", vecs[i].name), got_fl, vecs[i].flags);
      chki($sformatf("%s latency", vecs[i].name), got_lat, vecs[i].lat);
    end

    // Backpressure: result held while a competing issue is presented.
    @(negedge clock);
    io.vs2 = {8{32'h40800000}};
    io.vl = 4'd1;
    io.issue_valid = 1'b1;
    @(posedge clock); #1;
    io.issue_valid = 1'b0;
    n = 0;
    while (!io.result_valid && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    chk1("bp reached done", io.result_valid, 1'b1);
    @(negedge clock);
    io.vs2 = {8{32'h40000000}};
    io.vl = 4'd8;
    io.issue_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      chk1("bp result_valid held", io.result_valid, 1'b1);
      chkv("bp vd held", io.vd, {224'h0, 32'h40000000});
      chk5("bp fflags held", io.fflags, 5'b0);
      chk1("bp issue_ready low", io.issue_ready, 1'b0);
    end
    io.issue_valid = 1'b0;
    @(negedge clock);
    io.result_ready = 1'b1;
    @(posedge clock); #1;
    io.result_ready = 1'b0;
    chk1("bp issue_ready after release", io.issue_ready, 1'b1);
    @(posedge clock); #1;
    chk1("bp blocked issue not started", io.issue_ready, 1'b1);
    chk1("bp no spurious result", io.result_valid, 1'b0);

    // Reset pulse while lane 0 is iterating.
    @(negedge clock);
    io.vs2 = {8{32'h40000000}};
    io.vl = 4'd1;
    io.issue_valid = 1'b1;
    @(posedge clock); #1;
    io.issue_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk1("mid-iterate busy", io.issue_ready, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk1("mid-reset issue_ready", io.issue_ready, 1'b1);
    chk1("mid-reset result_valid", io.result_valid, 1'b0);
    chkv("mid-reset vd", io.vd, '0);
    chk5("mid-reset fflags", io.fflags, 5'b0);
    @(posedge clock); #1;
    chk1("mid-reset held result_valid", io.result_valid, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    run_vec(vecs[1].vs2, vecs[1].vl, got_vd, got_fl, got_lat);
    chkv("post-reset vd", got_vd, vecs[1].vd);
    chk5("post-reset fflags", got_fl, vecs[1].flags);
    chki("post-reset latency", got_lat, vecs[1].lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
